// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined RV32I control decoder: opcodes, select codes,
// ALU codes and the registered control bundle.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_M  = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imme_sel_e;

  typedef enum logic [1:0] {
    RD_ALU = 2'd0,
    RD_MEM = 2'd1,
    RD_PC4 = 2'd2,
    RD_IMM = 2'd3
  } rd_sel_e;

  typedef enum logic [1:0] {
    RS1_REG  = 2'd0,
    RS1_PC   = 2'd1,
    RS1_ZERO = 2'd2
  } rs1_sel_e;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b01000;
  localparam logic [4:0] ALU_MUL  = 5'b10000;
  localparam logic [4:0] ALU_MULH = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV  = 5'b10100;
  localparam logic [4:0] ALU_DIVU = 5'b10101;
  localparam logic [4:0] ALU_REM  = 5'b10110;
  localparam logic [4:0] ALU_REMU = 5'b10111;

  // Branch compares live in the upper half of the base ALU code space.
  function automatic logic [4:0] alu_branch(input logic [2:0] funct3);
    return {2'b01, funct3};
  endfunction

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] alu_ctrl;
    imme_sel_e  imme_sel;
    rd_sel_e    rd_sel;
    rs1_sel_e   rs1_sel;
    logic       reg_write;
    logic       mem_write;
    logic       load;
    logic       store;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       illegal;
  } ctrl_bundle_t;

endpackage

// File: rtl/pipe_decode_ctrl_inst_decode.sv
// Combinational RV32I instruction decoder producing the ID/EX control bundle.
// Define RV32M_EN to decode the M extension; otherwise M encodings are illegal.
module inst_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]  inst,
  output ctrl_bundle_t ctrl,
  output logic         rs1_used,
  output logic         rs2_used
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       writes_rd;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  always_comb begin
    ctrl      = '0;
    ctrl.rd   = inst[11:7];
    ctrl.rs1  = inst[19:15];
    ctrl.rs2  = inst[24:20];
    writes_rd = 1'b0;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;

    case (opcode)
      OP_R: begin
        writes_rd = 1'b1;
        rs2_used  = 1'b1;
        if (funct7 == FUNCT7_M) begin
`ifdef RV32M_EN
          ctrl.alu_ctrl = {2'b10, funct3};
`else
          ctrl.alu_ctrl = {2'b00, funct3};
          ctrl.illegal  = 1'b1;
`endif
        end else begin
          ctrl.alu_ctrl = {1'b0, inst[30], funct3};
        end
      end
      OP_IMM: begin
        writes_rd     = 1'b1;
        // Only the shift-right form uses bit 30 to pick arithmetic vs logical.
        ctrl.alu_ctrl = {1'b0, (funct3 == 3'b101) & inst[30], funct3};
      end
      OP_LOAD: begin
        writes_rd   = 1'b1;
        ctrl.load   = 1'b1;
        ctrl.rd_sel = RD_MEM;
      end
      OP_STORE: begin
        ctrl.store     = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.imme_sel  = IMM_S;
        rs2_used       = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.imme_sel = IMM_B;
        ctrl.rs1_sel  = RS1_PC;
        ctrl.alu_ctrl = alu_branch(funct3);
        rs2_used      = 1'b1;
      end
      OP_JAL: begin
        writes_rd     = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.imme_sel = IMM_J;
        ctrl.rd_sel   = RD_PC4;
        ctrl.rs1_sel  = RS1_PC;
        rs1_used      = 1'b0;
      end
      OP_JALR: begin
        writes_rd   = 1'b1;
        ctrl.jalr   = 1'b1;
        ctrl.rd_sel = RD_PC4;
      end
      OP_LUI: begin
        writes_rd     = 1'b1;
        ctrl.imme_sel = IMM_U;
        ctrl.rd_sel   = RD_IMM;
        ctrl.rs1_sel  = RS1_ZERO;
        rs1_used      = 1'b0;
      end
      OP_AUIPC: begin
        writes_rd     = 1'b1;
        ctrl.imme_sel = IMM_U;
        ctrl.rs1_sel  = RS1_PC;
        rs1_used      = 1'b0;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase

    ctrl.reg_write = writes_rd & ~ctrl.illegal & (inst[11:7] != 5'd0);
  end

endmodule

// File: rtl/pipe_decode_ctrl.sv
// Registered ID/EX control decoder with valid/ready handshake, load-use bubble
// insertion, EX flush and a saturating bubble counter. RV32M_EN enables M decode.
module pipe_decode_ctrl
  import ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            inst,
  input  logic [XLEN-1:0]        pc,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_alu_ctrl,
  output logic [2:0]             out_imme_sel,
  output logic [1:0]             out_rd_sel,
  output logic [1:0]             out_rs1_sel,
  output logic                   out_reg_write,
  output logic                   out_mem_write,
  output logic                   out_load,
  output logic                   out_store,
  output logic                   out_branch,
  output logic                   out_jal,
  output logic                   out_jalr,
  output logic                   out_illegal,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

  ctrl_bundle_t           dec_ctrl;
  ctrl_bundle_t           bundle_q, bundle_d;
  logic                   rs1_used, rs2_used;
  logic                   valid_q, valid_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   hazard;
  logic                   accept;

  inst_decode u_inst_decode (
    .inst     (inst),
    .ctrl     (dec_ctrl),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  // A held load only blocks an incoming instruction that actually reads its rd.
  always_comb begin
    hazard = in_valid & valid_q & bundle_q.load & (bundle_q.rd != 5'd0) &
             ((rs1_used & (dec_ctrl.rs1 == bundle_q.rd)) |
              (rs2_used & (dec_ctrl.rs2 == bundle_q.rd)));
    in_ready = ((~valid_q | out_ready) & ~hazard) | flush;
    accept   = in_valid & in_ready & ~flush;
  end

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec_ctrl;
      pc_d     = pc;
    end else if (out_ready) begin
      // The load drains while the dependent instruction waits: one bubble.
      valid_d = 1'b0;
      if (hazard && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_rd        = bundle_q.rd;
  assign out_rs1       = bundle_q.rs1;
  assign out_rs2       = bundle_q.rs2;
  assign out_alu_ctrl  = bundle_q.alu_ctrl;
  assign out_imme_sel  = bundle_q.imme_sel;
  assign out_rd_sel    = bundle_q.rd_sel;
  assign out_rs1_sel   = bundle_q.rs1_sel;
  assign out_reg_write = bundle_q.reg_write;
  assign out_mem_write = bundle_q.mem_write;
  assign out_load      = bundle_q.load;
  assign out_store     = bundle_q.store;
  assign out_branch    = bundle_q.branch;
  assign out_jal       = bundle_q.jal;
  assign out_jalr      = bundle_q.jalr;
  assign out_illegal   = bundle_q.illegal;
  assign stall_cnt     = cnt_q;

endmodule

// File: doc/pipe_decode_ctrl.md
# pipe_decode_ctrl

Registered, pipelined successor to the single-cycle control decoder. It decodes one RV32I instruction per cycle (optional RV32M) into the ID/EX control bundle and holds it in an output register with a valid/ready handshake. It detects load-use hazards and inserts exactly one bubble for each. It drops in-flight work on a branch/jump flush from EX and keeps a saturating count of inserted bubbles. It sits between the fetch/IF-ID register and the execute stage.

## Interface
- XLEN, 32, width of the PC carried with the instruction
- STALL_CNT_W, 16, width of the bubble counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  block accepts the instruction this cycle
- inst  in  32  instruction word
- pc  in  XLEN  PC of inst
- flush  in  1  redirect from EX; kill the held and incoming instruction
- out_valid  out  1  control bundle valid
- out_ready  in  1  EX accepts the bundle
- out_pc  out  XLEN  registered pc
- out_rd, out_rs1, out_rs2  out  5 each  inst[11:7], inst[19:15], inst[24:20]
- out_alu_ctrl  out  5  ALU operation
- out_imme_sel  out  3  0=I, 1=S, 2=B, 3=U, 4=J
- out_rd_sel  out  2  0=ALU, 1=memory, 2=PC+4, 3=immediate
- out_rs1_sel  out  2  0=rs1, 1=PC, 2=zero
- out_reg_write, out_mem_write, out_load, out_store, out_branch, out_jal, out_jalr  out  1 each  decoded controls
- out_illegal  out  1  unsupported opcode or funct
- stall_cnt  out  STALL_CNT_W  load-use bubbles inserted since reset

## Operation
- Opcodes:
  - R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111.
  - Any other opcode sets out_illegal=1 and forces reg_write=0 and mem_write=0.
- ALU code:
  - R: {0, inst[30], funct3}.
  - I-ALU: {0, inst[30] only when funct3=101, funct3}.
  - load, store, jal, jalr, lui, auipc: ADD (00000).
  - branch: {0, 1, funct3}.
- Operand/writeback selects:
  - auipc, jal, branch: rs1_sel=PC.
  - lui: rs1_sel=zero, rd_sel=imm.
  - jal, jalr: rd_sel=PC+4.
  - load: rd_sel=memory.
- reg_write is 0 for store, branch, and illegal instructions, and for rd=0.
- Register usage:
  - rs1 is used by every opcode except jal, lui, auipc.
  - rs2 is used by R, store, branch.
- Load-use hazard: the output register holds a valid load with out_rd≠0, and the incoming inst uses a matching rs1 or rs2.
  - During a hazard, in_ready=0.
  - When the load leaves (out_ready=1), the register empties for one cycle and stall_cnt increments, saturating at all-ones.
  - The dependent instruction is accepted in the next cycle.
- in_ready = (!out_valid | out_ready) & !hazard | flush.
- Flush:
  - The register goes to out_valid=0 next cycle.
  - Any instruction accepted in the flush cycle is discarded.
  - Flush takes priority over hazard and load. No bubble is counted for a flush.
- While out_valid=1 and out_ready=0, all out_* signals hold stable.

## Timing
- Reset: out_valid=0, stall_cnt=0, all out_* bundle fields 0 (out_alu_ctrl=00000, out_illegal=0). in_ready=1 while in reset.
- Latency: one cycle. An instruction accepted at edge N appears with out_valid=1 after edge N.
- Throughput: one instruction per cycle when out_ready=1 and there is no hazard.
- Load-use costs exactly one bubble cycle.
- A reset asserted mid-operation clears the register and the counter immediately (asynchronous). The counter does not wrap.
- Simultaneous flush and hazard: flush wins. out_valid becomes 0, no count is taken, and in_ready=1.

## Configuration
- RV32M_EN defined: an R-type instruction with funct7=0000001 decodes as out_alu_ctrl={1, 0, funct3} (MUL..REMU) with reg_write=1.
- RV32M_EN undefined: such instructions set out_illegal=1, and out_alu_ctrl bit 4 is tied to 0.

## Structure
- Package ctrl_pkg holds:
  - opcode constants;
  - imme_sel, rd_sel, and rs1_sel encodings;
  - ALU code constants, including the M codes.
- One combinational sub-module, inst_decode, maps inst to the bundle plus rs1_used/rs2_used.
- pipe_decode_ctrl owns the output register, the handshake, hazard detection, flush, and the counter.

## Test plan
- Back-to-back add x1,x2,x3 (0x003100B3) then sub (0x40310133), out_ready=1 → out_valid high on consecutive cycles; alu_ctrl 00000 then 01000; reg_write=1.
- lw x5,0(x1) followed by add x6,x5,x7 → one out_valid=0 cycle between them; in_ready low for one cycle; stall_cnt=1.
- lw x0,0(x1) followed by add x6,x0,x7 → no bubble; stall_cnt unchanged.
- out_ready=0 for 3 cycles with beq held → bundle stable, in_ready=0; branch=1, imme_sel=2, rs1_sel=1.
- flush asserted with a load held and a dependent add incoming → out_valid=0 next cycle, add dropped, stall_cnt unchanged.
- mul x1,x2,x3 (0x023100B3) → with RV32M_EN, alu_ctrl=10000 and illegal=0; without it, illegal=1 and reg_write=0. Opcode 0x7F → illegal=1.
